mult_booth_seq: RTL and testbench

Sequential radix-4 modified-Booth signed multiplier for the MULT/DIV unit. It latches two operands on a start pulse and retires 2 multiplier bits per clock for WIDTH/2 iterations, using the Booth recoding of the triplet {Q[1], Q[0], q_1}. It returns the low WIDTH bits of the product with an overflow flag and a one-cycle ready pulse. It sits between the processor's execute-stage multdiv request and the writeback mux.

---
 rtl/mult_booth_seq.sv | 151 +++++++++++++++
 tb/tb_mult_booth_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_booth_seq.sv
// Sequential radix-4 modified-Booth signed multiplier.
// Latches A/B on a ctrl_mult pulse and retires two multiplier bits per clock
// for WIDTH/2 iterations. It returns the low WIDTH bits of the product, a
// signed-overflow flag and a one-cycle ready pulse.
// Optional feature macro: MULT_HI_RESULT_EN adds data_result_hi (upper half).
module mult_booth_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef MULT_HI_RESULT_EN
    ,
    output logic [WIDTH-1:0] data_result_hi
`endif
);

    localparam int ITERS = WIDTH / 2;
    localparam int CW    = $clog2(ITERS + 1);
    localparam int AW    = WIDTH + 2;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic            qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]   count_q, count_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic            exc_q, exc_d;
    logic            rdy_q, rdy_d;
`ifdef MULT_HI_RESULT_EN
    logic [WIDTH-1:0] hi_q, hi_d;
`endif

    logic [AW-1:0] m_ext, m_x2, addend, sum;
    logic [2:0]    trip;

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            count_q <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef MULT_HI_RESULT_EN
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            count_q <= count_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
`ifdef MULT_HI_RESULT_EN
            hi_q    <= hi_d;
`endif
        end
    end

    // Next state: a start pulse wins from any state; the last iteration moves to DONE.
    always_comb begin
        state_d = state_q;
        if (ctrl_mult) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (count_q == LAST) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Booth step: pick the addend from the recoded triplet, add, then shift right by 2.
    always_comb begin
        m_ext  = {{2{m_q[WIDTH-1]}}, m_q};
        m_x2   = m_ext << 1;
        trip   = {q_q[1:0], qm1_q};
        case (trip)
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_x2;
            3'b100:         addend = ~m_x2 + AW'(1);
            3'b101, 3'b110: addend = ~m_ext + AW'(1);
            default:        addend = '0;
        endcase
        sum     = acc_q + addend;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        count_d = count_q;
        if (ctrl_mult) begin
            acc_d   = '0;
            q_d     = data_operandB;
            qm1_d   = 1'b0;
            m_d     = data_operandA;
            count_d = '0;
        end else if (state_q == RUN) begin
            acc_d   = {{2{sum[AW-1]}}, sum[AW-1:2]};
            q_d     = {sum[1:0], q_q[WIDTH-1:2]};
            qm1_d   = q_q[1];
            count_d = count_q + CW'(1);
        end
    end

    // Result registers: written once when DONE retires; a start kills any pending ready.
    always_comb begin
        res_d = res_q;
        exc_d = exc_q;
        rdy_d = 1'b0;
`ifdef MULT_HI_RESULT_EN
        hi_d  = hi_q;
`endif
        if (!ctrl_mult && state_q == DONE) begin
            res_d = q_q;
            // Overflow unless the whole accumulator is a sign extension of the low half.
            exc_d = (acc_q != {AW{q_q[WIDTH-1]}});
            rdy_d = 1'b1;
`ifdef MULT_HI_RESULT_EN
            hi_d  = acc_q[WIDTH-1:0];
`endif
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q == RUN);
`ifdef MULT_HI_RESULT_EN
    assign data_result_hi = hi_q;
`endif

endmodule

// File: tb/tb_mult_booth_seq.sv
// Self-checking bench for mult_booth_seq (WIDTH=32): directed plan cases,
// restart/abort/reset scenarios and random operands against a 64-bit
// arithmetic reference.
module tb_mult_booth_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_mult = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
`ifdef MULT_HI_RESULT_EN
    logic [31:0] data_result_hi;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;
    logic        last_exc = 1'b0;

    mult_booth_seq #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
`ifdef MULT_HI_RESULT_EN
        ,
        .data_result_hi (data_result_hi)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: full signed product in plain 64-bit arithmetic.
    task automatic model(input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [63:0] pu;
        p  = longint'($signed(a)) * longint'($signed(b));
        pu = p;
        last_lo  = pu[31:0];
        last_hi  = pu[63:32];
        last_exc = (p != longint'($signed(pu[31:0])));
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".result"}, 64'(data_result), 64'(last_lo));
        chk({tag, ".exc"}, 64'(data_exception), 64'(last_exc));
`ifdef MULT_HI_RESULT_EN
        chk({tag, ".hi"}, 64'(data_result_hi), 64'(last_hi));
`endif
    endtask

    // Start (ctrl held for 'hold' edges), scramble operand inputs afterwards,
    // then watch 40 edges for the ready pulse, its position and busy length.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        int busy_cnt, rdy_edge, pulses, pre_pulses;
        ctrl_mult = 1'b1;
        data_operandA = a;
        data_operandB = b;
        pre_pulses = 0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (data_resultRDY) pre_pulses++;
        end
        ctrl_mult = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        busy_cnt = busy ? 1 : 0;
        rdy_edge = 0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (data_resultRDY) begin
                pulses++;
                if (rdy_edge == 0) rdy_edge = k;
            end
        end
        model(a, b);
        if (hold > 1) chk({tag, ".held_no_rdy"}, 64'(pre_pulses), 64'd0);
        chk({tag, ".rdy_edge"}, 64'(rdy_edge), 64'd17);
        chk({tag, ".pulses"}, 64'(pulses), 64'd1);
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd16);
        chk_outputs(tag);
    endtask

    initial begin
        int pulses;
        // Reset state
        #3;
        chk("reset.result", 64'(data_result), 64'd0);
        chk("reset.exc", 64'(data_exception), 64'd0);
        chk("reset.rdy", 64'(data_resultRDY), 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed plan cases
        run_op("3x5", 32'd3, 32'd5, 1);
        chk("3x5.const", 64'(data_result), 64'd15);
        run_op("m7x6", 32'hFFFF_FFF9, 32'd6, 1);
        chk("m7x6.const", 64'(data_result), 64'hFFFF_FFD6);
        run_op("min_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1);
        chk("min_x_m1.exc_const", 64'(data_exception), 64'd1);
        run_op("2p16sq", 32'h0001_0000, 32'h0001_0000, 1);
        chk("2p16sq.exc_const", 64'(data_exception), 64'd1);
        run_op("max_x1", 32'h7FFF_FFFF, 32'd1, 1);
        chk("max_x1.exc_const", 64'(data_exception), 64'd0);

        // Hold: result stays put without a start even if operands move
        data_operandA = 32'h1234_5678;
        data_operandB = 32'h9ABC_DEF0;
        repeat (5) @(posedge clk);
        #1;
        chk_outputs("hold");
        chk("hold.rdy", 64'(data_resultRDY), 64'd0);

        // Restart at E8: only the second operation completes
        ctrl_mult = 1'b1; data_operandA = 32'd3; data_operandB = 32'd5;
        @(posedge clk); #1;
        ctrl_mult = 1'b0;
        pulses = 0;
        repeat (7) begin @(posedge clk); #1; if (data_resultRDY) pulses++; end
        chk("restart8.pre_pulses", 64'(pulses), 64'd0);
        chk("restart8.old_kept", 64'(data_result), 64'h7FFF_FFFF);
        run_op("restart8", 32'd2, 32'd2, 1);

        // Restart on the DONE edge (E17): the first operation never reports
        ctrl_mult = 1'b1; data_operandA = 32'd3; data_operandB = 32'd5;
        @(posedge clk); #1;
        ctrl_mult = 1'b0;
        pulses = 0;
        repeat (16) begin @(posedge clk); #1; if (data_resultRDY) pulses++; end
        chk("restart_done.pre_pulses", 64'(pulses), 64'd0);
        run_op("restart_done", 32'd7, 32'd9, 1);

        // ctrl_mult held high: no completion until it falls
        run_op("held", 32'hFFFF_FFFD, 32'h0000_0100, 20);

        // Reset mid-operation
        ctrl_mult = 1'b1; data_operandA = 32'd3; data_operandB = 32'd5;
        @(posedge clk); #1;
        ctrl_mult = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset.result", 64'(data_result), 64'd0);
        chk("midreset.exc", 64'(data_exception), 64'd0);
        chk("midreset.rdy", 64'(data_resultRDY), 64'd0);
        chk("midreset.busy", 64'(busy), 64'd0);
`ifdef MULT_HI_RESULT_EN
        chk("midreset.hi", 64'(data_result_hi), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (data_resultRDY || busy) pulses++; end
        chk("midreset.quiet", 64'(pulses), 64'd0);
        run_op("post_reset", 32'd3, 32'd5, 1);

        // Random operands against the arithmetic reference
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) a = $urandom_range(0, 65535) - 32768;
            if (i % 4 == 2) b = {32{b[0]}} ^ 32'($urandom_range(0, 255));
            run_op($sformatf("rand%0d", i), a, b, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
